// File: rtl/video_timing_gen.sv
// Raster timing generator with selectable test patterns. One pixel/line counter
// pair drives blanking, sync, DE and RGB, all registered with a single cycle of latency.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic [11:0] hcount_o,
  output logic [11:0] vcount_o,
  output logic        frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] L_H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] L_H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] L_HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] L_HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] L_V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] L_V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] L_VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] L_VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] L_BAR_W   = 12'(H_ACTIVE / 8);

  logic [11:0] r_h;
  logic [11:0] r_v;
  logic [7:0]  r_fc;
  logic [1:0]  r_sel;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_hb;
  logic        w_vb;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;
  logic        w_fs;
  logic [1:0]  w_sel;
  logic [2:0]  w_bar;
  logic [23:0] w_rgb;

  assign w_h_wrap = (r_h == L_H_LAST);
  assign w_v_wrap = (r_v == L_V_LAST);
  assign w_hb     = (r_h >= L_H_ACT);
  assign w_vb     = (r_v >= L_V_ACT);
  assign w_de     = !w_hb && !w_vb;
  assign w_hs     = ((r_h >= L_HS_BEG) && (r_h < L_HS_END)) ? HS_POL : ~HS_POL;
  assign w_vs     = ((r_v >= L_VS_BEG) && (r_v < L_VS_END)) ? VS_POL : ~VS_POL;
  assign w_fs     = (r_h == 12'd0) && (r_v == 12'd0);
  // The new select already applies to pixel (0,0) of the frame that samples it.
  assign w_sel    = w_fs ? pat_sel_i : r_sel;
  assign w_bar    = 3'(r_h / L_BAR_W);

  always_comb begin
    w_rgb = 24'h000000;
    if (w_de) begin
      case (w_sel)
        2'd1: begin
          case (w_bar)
            3'd0:    w_rgb = 24'hFFFFFF;
            3'd1:    w_rgb = 24'hFFFF00;
            3'd2:    w_rgb = 24'h00FFFF;
            3'd3:    w_rgb = 24'h00FF00;
            3'd4:    w_rgb = 24'hFF00FF;
            3'd5:    w_rgb = 24'hFF0000;
            3'd6:    w_rgb = 24'h0000FF;
            default: w_rgb = 24'h000000;
          endcase
        end
        2'd2:    w_rgb = {r_h[10:3], r_v[9:2], r_fc};
        2'd3:    w_rgb = (r_h[6] ^ r_v[6]) ? 24'hFFFFFF : 24'h000000;
        default: w_rgb = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h           <= '0;
      r_v           <= '0;
      r_fc          <= '0;
      r_sel         <= '0;
      vh_blank_o    <= 2'b11;
      dvh_sync_o    <= {1'b0, ~VS_POL, ~HS_POL};
      vid_rgb_o     <= '0;
      hcount_o      <= '0;
      vcount_o      <= '0;
      frame_start_o <= 1'b0;
    end else if (cen_i) begin
      r_sel <= w_sel;
      if (w_h_wrap) begin
        r_h <= '0;
        if (w_v_wrap) begin
          r_v  <= '0;
          r_fc <= r_fc + 8'd1;
        end else begin
          r_v <= r_v + 12'd1;
        end
      end else begin
        r_h <= r_h + 12'd1;
      end
      vh_blank_o    <= {w_vb, w_hb};
      dvh_sync_o    <= {w_de, w_vs, w_hs};
      vid_rgb_o     <= w_rgb;
      hcount_o      <= r_h;
      vcount_o      <= r_v;
      frame_start_o <= w_fs;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: three instances (tiny raster, full-width
// line, mid-size raster with inverted hsync) checked by a queue scoreboard and vector tables.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  bl;
    logic [2:0]  sy;
    logic [23:0] rgb;
    logic [11:0] hc;
    logic [11:0] vc;
    logic        fs;
  } out_t;

  typedef struct {
    int h;
    int v;
    int fc;
    int sel;
  } mst_t;

  typedef struct {
    int          h;
    logic [23:0] rgb;
    logic        de;
  } vec_t;

  localparam out_t RST_A = {2'b11, 3'b000, 24'h0, 12'h0, 12'h0, 1'b0};
  localparam out_t RST_C = {2'b11, 3'b001, 24'h0, 12'h0, 12'h0, 1'b0};

  logic        rst_a, cen_a, rst_b, cen_b, rst_c, cen_c;
  logic [1:0]  pat_a, pat_b, pat_c;
  logic [1:0]  bl_a, bl_b, bl_c;
  logic [2:0]  sy_a, sy_b, sy_c;
  logic [23:0] rgb_a, rgb_b, rgb_c;
  logic [11:0] hc_a, hc_b, hc_c, vc_a, vc_b, vc_c;
  logic        fs_a, fs_b, fs_c;
  out_t        oa, oc;

  assign oa = {bl_a, sy_a, rgb_a, hc_a, vc_a, fs_a};
  assign oc = {bl_c, sy_c, rgb_c, hc_c, vc_c, fs_c};

  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
                     .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_a (
    .clk_i(clk), .rst_i(rst_a), .cen_i(cen_a), .pat_sel_i(pat_a),
    .vh_blank_o(bl_a), .dvh_sync_o(sy_a), .vid_rgb_o(rgb_a),
    .hcount_o(hc_a), .vcount_o(vc_a), .frame_start_o(fs_a));

  video_timing_gen #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_b (
    .clk_i(clk), .rst_i(rst_b), .cen_i(cen_b), .pat_sel_i(pat_b),
    .vh_blank_o(bl_b), .dvh_sync_o(sy_b), .vid_rgb_o(rgb_b),
    .hcount_o(hc_b), .vcount_o(vc_b), .frame_start_o(fs_b));

  video_timing_gen #(.H_ACTIVE(128), .H_FP(4), .H_SYNC(4), .H_BP(8),
                     .V_ACTIVE(80), .V_FP(2), .V_SYNC(2), .V_BP(4),
                     .HS_POL(1'b0), .VS_POL(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst_c), .cen_i(cen_c), .pat_sel_i(pat_c),
    .vh_blank_o(bl_c), .dvh_sync_o(sy_c), .vid_rgb_o(rgb_c),
    .hcount_o(hc_c), .vcount_o(vc_c), .frame_start_o(fs_c));

  int checks = 0;
  int errors = 0;

  out_t qa[$];
  out_t qc[$];
  mst_t sa, sc;
  out_t la, lc;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_color(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic out_t model(input mst_t s, input int pat, input int ha, input int hf,
                                 input int hs_w, input int va, input int vf, input int vs_w,
                                 input bit hp, input bit vp);
    out_t o;
    int   sel;
    bit   hb, vb, de, hs, vs;
    sel  = (s.h == 0 && s.v == 0) ? pat : s.sel;
    hb   = (s.h >= ha);
    vb   = (s.v >= va);
    de   = !hb && !vb;
    hs   = (s.h >= ha + hf && s.h < ha + hf + hs_w) ? hp : !hp;
    vs   = (s.v >= va + vf && s.v < va + vf + vs_w) ? vp : !vp;
    o.bl = {vb, hb};
    o.sy = {de, vs, hs};
    o.hc = 12'(s.h);
    o.vc = 12'(s.v);
    o.fs = (s.h == 0 && s.v == 0);
    o.rgb = 24'h0;
    if (de) begin
      case (sel)
        1: o.rgb = bar_color(s.h / (ha / 8));
        2: o.rgb = {8'(s.h >> 3), 8'(s.v >> 2), 8'(s.fc)};
        3: o.rgb = ((((s.h >> 6) ^ (s.v >> 6)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        default: o.rgb = 24'h0;
      endcase
    end
    return o;
  endfunction

  function automatic mst_t adv(input mst_t s, input int pat, input int ht, input int vt);
    if (s.h == 0 && s.v == 0) s.sel = pat;
    if (s.h == ht - 1) begin
      s.h = 0;
      if (s.v == vt - 1) begin
        s.v  = 0;
        s.fc = (s.fc + 1) % 256;
      end else begin
        s.v = s.v + 1;
      end
    end else begin
      s.h = s.h + 1;
    end
    return s;
  endfunction

  task automatic step_a(input logic c);
    out_t e;
    if (c) begin
      e  = model(sa, int'(pat_a), 16, 2, 2, 8, 1, 2, 1'b1, 1'b1);
      sa = adv(sa, int'(pat_a), 24, 12);
    end else begin
      e = la;
    end
    la = e;
    qa.push_back(e);
    cen_a = c;
    @(posedge clk);
    #1;
    cmp("a_scoreboard", 64'(oa), 64'(qa.pop_front()));
  endtask

  task automatic step_c(input logic c);
    out_t e;
    if (c) begin
      e  = model(sc, int'(pat_c), 128, 4, 4, 80, 2, 2, 1'b0, 1'b1);
      sc = adv(sc, int'(pat_c), 144, 88);
    end else begin
      e = lc;
    end
    lc = e;
    qc.push_back(e);
    cen_c = c;
    @(posedge clk);
    #1;
    cmp("c_scoreboard", 64'(oc), 64'(qc.pop_front()));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vb_tbl[9];
    int   n_de, n_hs, n_vs, n_fs, bad_hs, bad_vs, bad_fs, idx, nz, reached;
    mst_t px;

    vb_tbl[0] = '{0,    24'hFFFFFF, 1'b1};
    vb_tbl[1] = '{239,  24'hFFFFFF, 1'b1};
    vb_tbl[2] = '{240,  24'hFFFF00, 1'b1};
    vb_tbl[3] = '{480,  24'h00FFFF, 1'b1};
    vb_tbl[4] = '{720,  24'h00FF00, 1'b1};
    vb_tbl[5] = '{1679, 24'h0000FF, 1'b1};
    vb_tbl[6] = '{1680, 24'h000000, 1'b1};
    vb_tbl[7] = '{1919, 24'h000000, 1'b1};
    vb_tbl[8] = '{1920, 24'h000000, 1'b0};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    cen_a = 1'b1; cen_b = 1'b1; cen_c = 1'b1;
    pat_a = 2'd0; pat_b = 2'd1; pat_c = 2'd0;
    sa = '{0, 0, 0, 0};
    sc = '{0, 0, 0, 0};
    la = RST_A;
    lc = RST_C;

    // Tiny raster: reset values, then two full frames at cen=1
    repeat (3) @(posedge clk);
    #1;
    cmp("a_reset_state", 64'(oa), 64'(RST_A));
    pat_a = 2'd2;
    rst_a = 1'b0;
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0;
    for (int i = 0; i < 576; i++) begin
      if (i == 100) pat_a = 2'd1;
      step_a(1'b1);
      if (i == 0) begin
        cmp("a_first_sync", 64'(sy_a), 64'(3'b100));
        cmp("a_first_pos", 64'({hc_a, vc_a, fs_a}), 64'({12'd0, 12'd0, 1'b1}));
      end
      if (sy_a[2]) n_de++;
      if (sy_a[0]) begin
        n_hs++;
        if (hc_a != 12'd18 && hc_a != 12'd19) bad_hs++;
      end
      if (sy_a[1]) begin
        n_vs++;
        if (vc_a < 12'd9 || vc_a > 12'd10) bad_vs++;
      end
      if (fs_a) begin
        n_fs++;
        if (i % 288 != 0) bad_fs++;
      end
    end
    cmp("a_de_count", 64'(n_de), 64'(256));
    cmp("a_hsync_count", 64'(n_hs), 64'(48));
    cmp("a_vsync_count", 64'(n_vs), 64'(96));
    cmp("a_fs_count", 64'(n_fs), 64'(2));
    cmp("a_hsync_pos", 64'(bad_hs), 64'(0));
    cmp("a_vsync_lines", 64'(bad_vs), 64'(0));
    cmp("a_fs_period", 64'(bad_fs), 64'(0));
    // Clock enable high one cycle in three; held cycles must repeat the last output
    for (int i = 0; i < 300; i++) step_a((i % 3) == 0);
    rst_a = 1'b1;

    // Full-width line with colour bars
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    idx = 0;
    for (int k = 0; k < 1926; k++) begin
      @(posedge clk);
      #1;
      if (idx < 9 && k == vb_tbl[idx].h) begin
        cmp("b_bar_rgb", 64'(rgb_b), 64'(vb_tbl[idx].rgb));
        cmp("b_bar_de", 64'(sy_b[2]), 64'(vb_tbl[idx].de));
        cmp("b_bar_hcount", 64'(hc_b), 64'(vb_tbl[idx].h));
        idx++;
      end
    end
    cmp("b_vectors_applied", 64'(idx), 64'(9));
    rst_b = 1'b1;

    // Mid-size raster: select change mid-frame, checkerboard next frame
    @(posedge clk);
    #1;
    rst_c = 1'b0;
    nz = 0;
    reached = 0;
    for (int i = 0; i < 30000; i++) begin
      px = sc;
      if (px.fc == 0 && px.v == 40 && px.h == 0) pat_c = 2'd3;
      step_c(1'b1);
      if (px.fc == 0 && px.v >= 40 && rgb_c != 24'h0) nz++;
      if (px.fc == 1 && px.v == 0 && px.h == 64)
        cmp("c_checker_64_0", 64'(rgb_c), 64'(24'hFFFFFF));
      if (px.fc == 1 && px.v == 64 && px.h == 64)
        cmp("c_checker_64_64", 64'(rgb_c), 64'(24'h000000));
      if (px.fc == 1 && px.v == 66 && px.h == 100) begin
        reached = 1;
        break;
      end
    end
    cmp("c_midframe_select_held", 64'(nz), 64'(0));
    cmp("c_reached_reset_point", 64'(reached), 64'(1));

    // Asynchronous reset mid-line, checked before any clock edge
    #3;
    rst_c = 1'b1;
    #1;
    cmp("c_async_reset", 64'(oc), 64'(RST_C));
    @(posedge clk);
    #1;
    cmp("c_reset_held", 64'(oc), 64'(RST_C));
    pat_c = 2'd2;
    rst_c = 1'b0;
    sc = '{0, 0, 0, 0};
    lc = RST_C;
    for (int i = 0; i < 200; i++) begin
      step_c(1'b1);
      if (i == 0)
        cmp("c_restart", 64'({hc_c, vc_c, fs_c, rgb_c}), 64'({12'd0, 12'd0, 1'b1, 24'h0}));
      if (i == 16)
        cmp("c_gradient_16_0", 64'(rgb_c), 64'(24'h020000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator and test-pattern source for the 1080p60 HDMI path. It sits directly upstream of the video processing stage (`video_uut`) and drives that stage's `vh_blank_i`, `dvh_sync_i` and `vid_rgb_i` inputs from one set of pixel/line counters. A fixed set of test patterns is selectable at runtime, so downstream overlays can be checked without an external video source.

## Interface
Parameters:
- H_ACTIVE, 1920, active pixels per line (must be divisible by 8)
- H_FP, 88, horizontal front porch
- H_SYNC, 44, hsync width
- H_BP, 148, horizontal back porch
- V_ACTIVE, 1080, active lines
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset, asynchronous, active-high
- cen_i  in  1  clock enable; all state advances only when high
- pat_sel_i  in  2  pattern: 0 black, 1 colour bars, 2 gradient, 3 checkerboard
- vh_blank_o  out  2  [1] vblank, [0] hblank
- dvh_sync_o  out  3  [2] de, [1] vsync, [0] hsync
- vid_rgb_o  out  24  R[23:16] G[15:8] B[7:0]
- hcount_o  out  12  pixel index of the current output
- vcount_o  out  12  line index of the current output
- frame_start_o  out  1  one-enabled-cycle pulse with pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (2200). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (1125). Counters h, v are 12-bit and unsigned.
- Counter update, on each cycle with cen_i=1:
  - h increments. At H_TOTAL-1, h wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0 when h also wraps.
  - 8-bit frame counter `fc` increments on the v wrap.
- Decode from the current (h,v), registered into the outputs:
  - hblank = h ≥ H_ACTIVE
  - vblank = v ≥ V_ACTIVE
  - de = !hblank & !vblank
  - hsync is at active level HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
  - vsync is at active level VS_POL for whole lines V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, line-aligned (changes at h=0); otherwise ~VS_POL.
  - frame_start = (h==0 && v==0)
  - hcount_o = h, vcount_o = v
- RGB is 0 whenever de=0. When de=1:
  - pattern 0: 0.
  - pattern 1: 8 bars of width BW = H_ACTIVE/8. Bar i = h/BW. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - pattern 2: R = h[10:3], G = v[9:2], B = fc.
  - pattern 3: FFFFFF if h[6]^v[6], else 000000.
- pat_sel_i is sampled only at frame_start (decode of h=0, v=0). A change mid-frame takes effect from the next frame. The latched select resets to 0.

## Timing
- Latency: outputs reflect the counter value present before that enabled edge. One enabled cycle from counter to output; all outputs are mutually aligned.
- cen_i=0: counters, fc, latched select and every output hold their values. The frame_start pulse stretches across the held cycles.
- Reset (asynchronous assert, any time, including mid-line):
  - h=0, v=0, fc=0, select=0.
  - vh_blank_o=2'b11.
  - dvh_sync_o={0, ~VS_POL, ~HS_POL}.
  - vid_rgb_o=0, hcount_o=0, vcount_o=0, frame_start_o=0.
- The first enabled edge after reset release outputs pixel (0,0) with de=1 and frame_start_o=1.
- hblank falls on the same output cycle that de rises (active lines). This gives downstream falling-edge detectors exactly one edge per line.
- vblank rises together with hblank=0 at v=V_ACTIVE, h=0. It falls at v=0, h=0.

## Test plan
- Small parameters (H 16/2/2/4 → H_TOTAL 24; V 8/1/2/1 → V_TOTAL 12), cen_i=1, run 2 frames:
  - de high 16 of every 24 cycles on lines 0–7.
  - hsync high at h=18,19.
  - vsync high for lines 9–10.
  - frame_start every 288 cycles.
- Reset released, first enabled edge: dvh_sync_o=3'b100, hcount_o=0, vcount_o=0, frame_start_o=1. While rst_i is high: vh_blank_o=2'b11 and the inactive sync values.
- pat_sel_i=1 with default parameters:
  - rgb = FFFFFF at h=0..239.
  - rgb = FFFF00 at h=240.
  - rgb = 000000 at h=1680..1919.
  - rgb = 0 at h=1920.
- pat_sel_i changed 0→3 at mid-frame (v=500): rgb stays 0 until the next frame. On the next frame, pixel (64,0) = FFFFFF and pixel (64,64) = 000000.
- Toggle cen_i in a 1-of-3 pattern:
  - output sequence equals the cen_i=1 run, decimated;
  - outputs are constant during low cycles.
- Assert rst_i asynchronously mid-line (h=700, v=300):
  - outputs go to reset values immediately, without a clock edge;
  - the next enabled edge after release restarts at (0,0) with fc=0.
